piso_serializer: RTL and testbench

- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock on sout.
- Acts as the source end for the team's serial shift-register chains: sout/sout_valid drive a serial data input directly.
- Supports back-to-back words with no idle bit between them.

---
 rtl/piso_serializer.sv | 99 +++++++++
 tb/tb_piso_serializer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready
// handshake and emits one bit per clock on sout, back-to-back words without gaps.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic [WIDTH-1:0] din_shifted;
  logic [WIDTH-1:0] shreg_shifted;
  logic             din_first;
  logic             shreg_next;

  assign load_ready = (state == IDLE) || ((state == SHIFT) && (cnt == LAST));
  assign accept     = load_valid && load_ready;

  // Only the shift direction depends on bit order; timing is shared below.
  always_comb begin
    din_shifted   = '0;
    shreg_shifted = '0;
    din_first     = 1'b0;
    shreg_next    = 1'b0;
    if (MSB_FIRST) begin
      din_shifted   = din << 1;
      shreg_shifted = shreg << 1;
      din_first     = din[WIDTH-1];
      shreg_next    = shreg[WIDTH-1];
    end else begin
      din_shifted   = din >> 1;
      shreg_shifted = shreg >> 1;
      din_first     = din[0];
      shreg_next    = shreg[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg      <= din_shifted;
            sout       <= din_first;
            sout_valid <= 1'b1;
            cnt        <= '0;
            done       <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != LAST) begin
            sout  <= shreg_next;
            shreg <= shreg_shifted;
            cnt   <= cnt + CW'(1);
            done  <= ((cnt + CW'(1)) == LAST);
          end else if (accept) begin
            // Next word loads while the last bit is on sout, so there is no gap.
            shreg      <= din_shifted;
            sout       <= din_first;
            sout_valid <= 1'b1;
            cnt        <= '0;
            done       <= 1'b0;
          end else begin
            state      <= IDLE;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer: an MSB-first and an LSB-first
// instance share clk and clear; a 4-stage chain captures the MSB-first serial stream.
module tb_piso_serializer;

  logic       clk;
  logic       clear;
  logic [3:0] din;
  logic       load_valid;
  logic       load_ready;
  logic       sout;
  logic       sout_valid;
  logic       done;

  logic [3:0] din_l;
  logic       load_valid_l;
  logic       load_ready_l;
  logic       sout_l;
  logic       sout_valid_l;
  logic       done_l;

  logic [3:0] chain;

  int tests = 0;
  int fails = 0;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .clear      (clear),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .clear      (clear),
    .din        (din_l),
    .load_valid (load_valid_l),
    .load_ready (load_ready_l),
    .sout       (sout_l),
    .sout_valid (sout_valid_l),
    .done       (done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream serial chain: shifts in sout only while sout_valid is high.
  always @(posedge clk) begin
    if (!clear) chain <= 4'b0000;
    else if (sout_valid) chain <= {chain[2:0], sout};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0; load_valid = 1'b0; load_valid_l = 1'b0; din = 4'b0; din_l = 4'b0;
    step(); step();
    tests++;
    if ({sout, sout_valid, done} !== 3'b000) begin
      fails++; $display("[TB] FAIL reset_outputs: got %b expected 000", {sout, sout_valid, done});
    end
    tests++;
    if (load_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_ready: got %b expected 1", load_ready);
    end
    tests++;
    if ({sout_l, sout_valid_l, done_l, load_ready_l} !== 4'b0001) begin
      fails++; $display("[TB] FAIL reset_lsb: got %b expected 0001", {sout_l, sout_valid_l, done_l, load_ready_l});
    end
    clear = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [3:0] pat;
    pat = 4'b1010;
    din = pat; load_valid = 1'b1;
    step();
    load_valid = 1'b0; din = 4'b0101;
    for (int c = 1; c <= 4; c++) begin
      tests++;
      if (sout !== pat[4-c] || sout_valid !== 1'b1 || done !== (c == 4)) begin
        fails++;
        $display("[TB] FAIL single_bit%0d: got sout=%b valid=%b done=%b expected sout=%b valid=1 done=%b",
                 c, sout, sout_valid, done, pat[4-c], (c == 4));
      end
      tests++;
      if (load_ready !== (c == 4)) begin
        fails++; $display("[TB] FAIL single_ready%0d: got %b expected %b", c, load_ready, (c == 4));
      end
      step();
    end
    tests++;
    if ({sout, sout_valid, done} !== 3'b000) begin
      fails++; $display("[TB] FAIL single_idle: got %b expected 000", {sout, sout_valid, done});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    pat = 8'b1100_0011;
    din = 4'b1100; load_valid = 1'b1;
    step();
    din = 4'b0011;
    for (int c = 1; c <= 8; c++) begin
      tests++;
      if (sout !== pat[8-c] || sout_valid !== 1'b1 || done !== (c == 4 || c == 8)) begin
        fails++;
        $display("[TB] FAIL b2b_bit%0d: got sout=%b valid=%b done=%b expected sout=%b valid=1 done=%b",
                 c, sout, sout_valid, done, pat[8-c], (c == 4 || c == 8));
      end
      tests++;
      if (load_ready !== (c == 4 || c == 8)) begin
        fails++; $display("[TB] FAIL b2b_ready%0d: got %b expected %b", c, load_ready, (c == 4 || c == 8));
      end
      step();
      if (c == 4) begin
        load_valid = 1'b0; din = 4'b0000;
      end
    end
    tests++;
    if ({sout, sout_valid, done} !== 3'b000) begin
      fails++; $display("[TB] FAIL b2b_idle: got %b expected 000", {sout, sout_valid, done});
    end
  endtask

  task automatic test_busy_holdoff();
    logic [7:0] pat;
    pat = 8'b0110_1111;
    din = 4'b0110; load_valid = 1'b1;
    step();
    din = 4'b1111;
    for (int c = 1; c <= 8; c++) begin
      tests++;
      if (sout !== pat[8-c] || sout_valid !== 1'b1 || done !== (c == 4 || c == 8)) begin
        fails++;
        $display("[TB] FAIL busy_bit%0d: got sout=%b valid=%b done=%b expected sout=%b valid=1 done=%b",
                 c, sout, sout_valid, done, pat[8-c], (c == 4 || c == 8));
      end
      tests++;
      if (load_ready !== (c == 4 || c == 8)) begin
        fails++; $display("[TB] FAIL busy_ready%0d: got %b expected %b", c, load_ready, (c == 4 || c == 8));
      end
      step();
      if (c == 4) begin
        load_valid = 1'b0; din = 4'b0000;
      end
    end
    tests++;
    if (sout_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL busy_idle: got %b expected 0", sout_valid);
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] words [2];
    logic [3:0] w;
    words[0] = 4'b1000;
    words[1] = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      w = words[k];
      din_l = w; load_valid_l = 1'b1;
      step();
      load_valid_l = 1'b0; din_l = 4'b0000;
      for (int c = 1; c <= 4; c++) begin
        tests++;
        if (sout_l !== w[c-1] || sout_valid_l !== 1'b1 || done_l !== (c == 4)) begin
          fails++;
          $display("[TB] FAIL lsb_w%0d_bit%0d: got sout=%b valid=%b done=%b expected sout=%b valid=1 done=%b",
                   k, c, sout_l, sout_valid_l, done_l, w[c-1], (c == 4));
        end
        step();
      end
      tests++;
      if ({sout_l, sout_valid_l, done_l} !== 3'b000) begin
        fails++; $display("[TB] FAIL lsb_idle%0d: got %b expected 000", k, {sout_l, sout_valid_l, done_l});
      end
    end
  endtask

  task automatic test_reset_mid_word();
    din = 4'b1111; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      tests++;
      if (sout !== 1'b1 || sout_valid !== 1'b1) begin
        fails++; $display("[TB] FAIL midrst_bit%0d: got sout=%b valid=%b expected 1 1", c, sout, sout_valid);
      end
      if (c == 1) step();
    end
    clear = 1'b0; load_valid = 1'b1; din = 4'b1010;
    step();
    tests++;
    if ({sout, sout_valid, done, load_ready} !== 4'b0001) begin
      fails++; $display("[TB] FAIL midrst_after: got %b expected 0001", {sout, sout_valid, done, load_ready});
    end
    step();
    tests++;
    if ({sout, sout_valid, done} !== 3'b000) begin
      fails++; $display("[TB] FAIL midrst_hs_ignored: got %b expected 000", {sout, sout_valid, done});
    end
    clear = 1'b1; load_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if ({sout, sout_valid, done} !== 3'b000) begin
        fails++; $display("[TB] FAIL midrst_quiet%0d: got %b expected 000", c, {sout, sout_valid, done});
      end
    end
    // Glitch clear low strictly between edges; the word in flight must survive.
    din = 4'b1111; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    #2 clear = 1'b0;
    #2 clear = 1'b1;
    step();
    for (int c = 2; c <= 4; c++) begin
      tests++;
      if (sout !== 1'b1 || sout_valid !== 1'b1 || done !== (c == 4)) begin
        fails++;
        $display("[TB] FAIL glitch_bit%0d: got sout=%b valid=%b done=%b expected 1 1 %b",
                 c, sout, sout_valid, done, (c == 4));
      end
      step();
    end
    tests++;
    if (sout_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL glitch_idle: got %b expected 0", sout_valid);
    end
  endtask

  task automatic test_loopback_random();
    int         rem;
    logic [3:0] word;
    logic       exp_ready;
    logic       acc;
    logic       exp_sout;
    din = 4'b1011; load_valid = 1'b1;
    step();
    load_valid = 1'b0; din = 4'b0000;
    for (int c = 0; c < 7; c++) step();
    tests++;
    if (chain !== 4'b1011) begin
      fails++; $display("[TB] FAIL loopback_chain: got %b expected 1011", chain);
    end
    tests++;
    if (sout_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL loopback_idle: got %b expected 0", sout_valid);
    end
    rem = 0;
    word = 4'b0000;
    for (int n = 0; n < 60; n++) begin
      if (!load_valid) begin
        load_valid = ($urandom_range(0, 2) == 0);
        din = 4'($urandom);
      end
      exp_ready = (rem <= 1);
      tests++;
      if (load_ready !== exp_ready) begin
        fails++; $display("[TB] FAIL rand_ready%0d: got %b expected %b", n, load_ready, exp_ready);
      end
      acc = load_valid && exp_ready;
      step();
      if (acc) begin
        word = din; rem = 4; load_valid = 1'b0;
      end else if (rem > 0) begin
        rem--;
      end
      exp_sout = (rem > 0) ? word[rem-1] : 1'b0;
      tests++;
      if (sout_valid !== (rem > 0) || sout !== exp_sout || done !== (rem == 1)) begin
        fails++;
        $display("[TB] FAIL rand_cycle%0d: got sout=%b valid=%b done=%b expected sout=%b valid=%b done=%b",
                 n, sout, sout_valid, done, exp_sout, (rem > 0), (rem == 1));
      end
    end
    load_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();
    tests++;
    if (sout_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL rand_drain: got %b expected 0", sout_valid);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_holdoff();
    test_lsb_first();
    test_reset_mid_word();
    test_loopback_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
